// File: rtl/sfx_scheduler.sv
// Fixed-priority, preemptive arbiter that routes four sound-effect sources onto one
// synthesizer channel and times each note's audible window and trailing silent gap.
module sfx_scheduler #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned DUR_MS = 150,
    parameter int unsigned GAP_MS = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_req,
    input  logic [47:0] i_req_freq,
    output logic [11:0] o_syn_freq,
    output logic        o_syn_signal,
    output logic        o_busy,
    output logic [1:0]  o_active_id,
    output logic        o_dropped
);
    localparam int unsigned TICK = CLK_HZ / 1000;
    localparam int unsigned PW   = (TICK > 1) ? $clog2(TICK) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StPlay, StGap} state_e;

    state_e        r_state;
    state_e        w_next_state;
    logic [3:0]    r_pending;
    logic [11:0]   r_freq [4];
    logic [1:0]    r_active_id;
    logic [11:0]   r_syn_freq;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_ms;
    logic          r_dropped;

    logic [3:0] w_req_valid;
    logic [3:0] w_req_zero;
    logic [3:0] w_grant_mask;
    logic [1:0] w_win_id;
    logic       w_any_pend;
    logic       w_preempt;
    logic       w_tick;
    logic       w_dur_done;
    logic       w_gap_done;
    logic       w_grant;
    logic       w_clr_cnt;
    logic       w_note_end;

    always_comb begin
        w_req_valid = '0;
        w_req_zero  = '0;
        for (int i = 0; i < 4; i++) begin
            w_req_valid[i] = i_req[i] && (i_req_freq[12*i +: 12] != 12'd0);
            w_req_zero[i]  = i_req[i] && (i_req_freq[12*i +: 12] == 12'd0);
        end
    end

    // Ascending scan: the highest pending index is the last one written.
    always_comb begin
        w_win_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i]) w_win_id = 2'(i);
        end
    end

    assign w_any_pend   = |r_pending;
    assign w_preempt    = w_any_pend && (w_win_id > r_active_id);
    assign w_tick       = (r_pre == PW'(TICK - 1));
    assign w_dur_done   = w_tick && (r_ms == 16'(DUR_MS - 1));
    assign w_gap_done   = w_tick && (r_ms == 16'(GAP_MS - 1));
    assign w_grant_mask = 4'(w_grant) << w_win_id;

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_clr_cnt    = 1'b0;
        w_note_end   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_clr_cnt = 1'b1;
                if (w_any_pend) begin
                    w_grant      = 1'b1;
                    w_next_state = StStart;
                end
            end
            StStart: begin
                w_clr_cnt    = 1'b1;
                w_next_state = StPlay;
            end
            StPlay: begin
                if (w_preempt) begin
                    w_grant      = 1'b1;
                    w_next_state = StStart;
                end else if (w_dur_done) begin
                    w_note_end   = 1'b1;
                    w_clr_cnt    = 1'b1;
                    w_next_state = (GAP_MS == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (w_preempt) begin
                    w_grant      = 1'b1;
                    w_next_state = StStart;
                end else if (w_gap_done) begin
                    w_next_state = StIdle;
                end
            end
            default: w_next_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_pending   <= '0;
            r_active_id <= '0;
            r_syn_freq  <= '0;
            r_pre       <= '0;
            r_ms        <= '0;
            r_dropped   <= 1'b0;
            for (int i = 0; i < 4; i++) r_freq[i] <= '0;
        end else begin
            r_state   <= w_next_state;
            r_dropped <= |w_req_zero;
            // Set is applied after clear so a request colliding with its own grant survives.
            r_pending <= (r_pending & ~w_grant_mask) | w_req_valid;
            for (int i = 0; i < 4; i++) begin
                if (w_req_valid[i]) r_freq[i] <= i_req_freq[12*i +: 12];
            end
            if (w_grant) begin
                r_active_id <= w_win_id;
                r_syn_freq  <= r_freq[w_win_id];
            end else if (w_note_end) begin
                r_syn_freq <= '0;
            end
            if (w_clr_cnt) begin
                r_pre <= '0;
                r_ms  <= '0;
            end else if (w_tick) begin
                r_pre <= '0;
                r_ms  <= r_ms + 16'd1;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    assign o_syn_freq   = r_syn_freq;
    assign o_syn_signal = (r_state == StStart);
    assign o_busy       = (r_state != StIdle);
    assign o_active_id  = r_active_id;
    assign o_dropped    = r_dropped;
endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: vector table, directed multi-cycle sequences and a random run
// against a countdown-based reference model; a second instance covers the zero-gap case.
module tb_sfx_scheduler;
    localparam int unsigned CLK_HZ = 4000;
    localparam int unsigned DUR    = 3;
    localparam int unsigned GAP    = 2;
    localparam int unsigned TICK   = CLK_HZ / 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [47:0] freq = '0;
    logic [11:0] syn_freq, z_freq;
    logic        syn_sig, z_sig, busy, z_busy, dropped, z_dropped;
    logic [1:0]  act_id, z_id;

    sfx_scheduler #(.CLK_HZ(CLK_HZ), .DUR_MS(DUR), .GAP_MS(GAP)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_freq(freq),
        .o_syn_freq(syn_freq), .o_syn_signal(syn_sig), .o_busy(busy),
        .o_active_id(act_id), .o_dropped(dropped)
    );

    sfx_scheduler #(.CLK_HZ(CLK_HZ), .DUR_MS(DUR), .GAP_MS(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_freq(freq),
        .o_syn_freq(z_freq), .o_syn_signal(z_sig), .o_busy(z_busy),
        .o_active_id(z_id), .o_dropped(z_dropped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int p_t[$];
    int p_f[$];
    int p_id[$];
    int z_t[$];

    // Reference model: a mode plus a cycle countdown for the current window.
    localparam int M_IDLE = 0, M_START = 1, M_PLAY = 2, M_GAP = 3;
    int       m_mode = M_IDLE;
    int       m_left = 0;
    int       m_act  = 0;
    int       m_out  = 0;
    bit       m_drop = 0;
    bit [3:0] m_pend = '0;
    int       m_freq[4] = '{0, 0, 0, 0};

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int  hi;
        bit  has_p;
        bit  grant;
        if (rst) begin
            m_mode = M_IDLE; m_left = 0; m_act = 0; m_out = 0; m_drop = 0; m_pend = '0;
            for (int i = 0; i < 4; i++) m_freq[i] = 0;
            return;
        end
        has_p = 0; hi = 0; grant = 0;
        for (int i = 0; i < 4; i++) if (m_pend[i]) begin has_p = 1; hi = i; end
        m_drop = 0;
        for (int i = 0; i < 4; i++) if (req[i] && freq[12*i +: 12] == 0) m_drop = 1;
        case (m_mode)
            M_IDLE:  grant = has_p;
            M_START: begin m_mode = M_PLAY; m_left = DUR * TICK; end
            M_PLAY: begin
                if (has_p && hi > m_act) grant = 1;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_out  = 0;
                        m_mode = (GAP == 0) ? M_IDLE : M_GAP;
                        m_left = GAP * TICK;
                    end
                end
            end
            default: begin
                if (has_p && hi > m_act) grant = 1;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
        if (grant) begin
            m_mode = M_START; m_act = hi; m_out = m_freq[hi]; m_pend[hi] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (req[i] && freq[12*i +: 12] != 0) begin
                m_pend[i] = 1;
                m_freq[i] = int'(freq[12*i +: 12]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("model_freq", int'(syn_freq), m_out);
        check("model_signal", int'(syn_sig), int'(m_mode == M_START));
        check("model_busy", int'(busy), int'(m_mode != M_IDLE));
        check("model_dropped", int'(dropped), int'(m_drop));
        if (m_mode != M_IDLE) check("model_active_id", int'(act_id), m_act);
        if (syn_sig) begin
            p_t.push_back(cyc); p_f.push_back(int'(syn_freq)); p_id.push_back(int'(act_id));
        end
        if (z_sig) z_t.push_back(cyc);
    endtask

    task automatic idle_n(input int n);
        req = '0; freq = '0;
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; req = '0; freq = '0;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic clear_mon();
        p_t.delete(); p_f.delete(); p_id.delete(); z_t.delete();
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [47:0] freq;
        int          reps;
        int          e_freq;
        bit          e_sig;
        bit          e_busy;
        int          e_id;
        bit          e_drop;
        bit          chk_id;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [3:0] rq, input logic [47:0] f, input int n,
                       input int ef, input bit es, input bit eb, input int ei, input bit ed,
                       input bit ci);
        vec_t v;
        v.rst = r; v.req = rq; v.freq = f; v.reps = n; v.e_freq = ef; v.e_sig = es;
        v.e_busy = eb; v.e_id = ei; v.e_drop = ed; v.chk_id = ci;
        tbl.push_back(v);
    endtask

    initial begin
        // Single request on source 1: pending, START, 12 PLAY, 8 GAP, then idle; then a drop.
        add(1, 4'b0000, 48'd0, 3, 0, 0, 0, 0, 0, 1);
        add(0, 4'b0000, 48'd0, 2, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0010, 48'(440) << 12, 1, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 48'd0, 1, 440, 1, 1, 1, 0, 1);
        add(0, 4'b0000, 48'd0, 12, 440, 0, 1, 1, 0, 1);
        add(0, 4'b0000, 48'd0, 8, 0, 0, 1, 1, 0, 1);
        add(0, 4'b0000, 48'd0, 2, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0100, 48'd0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 4'b0000, 48'd0, 3, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            for (int r = 0; r < tbl[k].reps; r++) begin
                rst = tbl[k].rst; req = tbl[k].req; freq = tbl[k].freq;
                cycle();
                check($sformatf("tbl%0d_freq", k), int'(syn_freq), tbl[k].e_freq);
                check($sformatf("tbl%0d_signal", k), int'(syn_sig), int'(tbl[k].e_sig));
                check($sformatf("tbl%0d_busy", k), int'(busy), int'(tbl[k].e_busy));
                check($sformatf("tbl%0d_dropped", k), int'(dropped), int'(tbl[k].e_drop));
                if (tbl[k].chk_id) check($sformatf("tbl%0d_id", k), int'(act_id), tbl[k].e_id);
            end
        end

        // Simultaneous requests on sources 0 and 2.
        do_reset(2); clear_mon();
        req = 4'b0101; freq = (48'(330) << 24) | 48'(262);
        cycle();
        idle_n(70);
        check("sim_pulses", p_t.size(), 2);
        if (p_t.size() == 2) begin
            check("sim_first_freq", p_f[0], 330);
            check("sim_first_id", p_id[0], 2);
            check("sim_second_freq", p_f[1], 262);
            check("sim_second_id", p_id[1], 0);
            check("sim_spacing", p_t[1] - p_t[0], 22);
        end
        check("gap0_pulses", z_t.size(), 2);
        if (z_t.size() == 2) check("gap0_spacing", z_t[1] - z_t[0], int'(DUR * TICK + 2));

        // Preemption by source 3, then a lower request waits for the 880 note to finish.
        do_reset(2); clear_mon();
        req = 4'b0001; freq = 48'(262);
        cycle();
        idle_n(6);
        req = 4'b1000; freq = 48'(880) << 36;
        cycle();
        req = '0; freq = '0;
        cycle();
        check("pre_signal", int'(syn_sig), 1);
        check("pre_id", int'(act_id), 3);
        check("pre_freq", int'(syn_freq), 880);
        idle_n(3);
        req = 4'b0010; freq = 48'(500) << 12;
        cycle();
        idle_n(60);
        check("pre_pulses", p_t.size(), 3);
        if (p_t.size() == 3) begin
            check("pre_ids0", p_id[0], 0);
            check("pre_ids1", p_id[1], 3);
            check("pre_ids2", p_id[2], 1);
            check("pre_late_freq", p_f[2], 500);
            check("pre_late_spacing", p_t[2] - p_t[1], 22);
        end

        // Request on source 2 colliding with its own grant is served twice.
        do_reset(2); clear_mon();
        req = 4'b0100; freq = 48'(700) << 24;
        cycle();
        cycle();
        idle_n(60);
        check("coll_pulses", p_t.size(), 2);
        if (p_t.size() == 2) begin
            check("coll_id0", p_id[0], 2);
            check("coll_id1", p_id[1], 2);
            check("coll_spacing", p_t[1] - p_t[0], 22);
        end

        // Reset in the middle of PLAY aborts the note.
        do_reset(2); clear_mon();
        req = 4'b0001; freq = 48'(300);
        cycle();
        idle_n(6);
        rst = 1'b1;
        cycle();
        check("rst_busy", int'(busy), 0);
        check("rst_freq", int'(syn_freq), 0);
        check("rst_signal", int'(syn_sig), 0);
        rst = 1'b0;
        idle_n(20);
        check("rst_pulses", p_t.size(), 1);

        // Random traffic against the reference model.
        do_reset(2);
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                req[i] = ($urandom_range(0, 19) == 0);
                freq[12*i +: 12] = ($urandom_range(0, 9) == 0) ? 12'd0
                                                                : 12'($urandom_range(1, 4095));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
